// File: rtl/m_or_cg_ctrl.sv
// Clock-enable request combiner: ORs masked requests into one registered gate
// enable, with a fixed wake-up latency before ack and programmable idle hysteresis.
module m_or_cg_ctrl #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             force_on,
  input  logic [CNT_W-1:0] idle_cycles,
  output logic             en,
  output logic [N_REQ-1:0] ack,
  output logic [1:0]       state
);

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] WAKE = 2'd1;
  localparam logic [1:0] ON   = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);

  logic [N_REQ-1:0] live;
  logic             any;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    live = req & ~mask;
    any  = (|live) | force_on;
    ack  = (state == ON) ? live : '0;
  end

  // en is its own flop so the gate enable never glitches on a state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      en    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        OFF: begin
          if (any) begin
            state <= WAKE;
            en    <= 1'b1;
            cnt   <= WAKE_LOAD;
          end
        end
        WAKE: begin
          if (cnt == '0) state <= ON;
          else           cnt   <= cnt - 1'b1;
        end
        ON: begin
          if (!any) begin
            state <= HOLD;
            cnt   <= idle_cycles;
          end
        end
        HOLD: begin
          if (any) begin
            state <= ON;
          end else if (cnt == '0) begin
            state <= OFF;
            en    <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= OFF;
          en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_or_cg_ctrl.sv
// Self-checking bench: directed timing scenarios plus randomized traffic compared
// every cycle against an edge-count/deadline model of the enable controller.
module tb_m_or_cg_ctrl;

  localparam int N_REQ    = 4;
  localparam int CNT_W    = 4;
  localparam int WAKE_CYC = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] mask;
  logic             force_on;
  logic [CNT_W-1:0] idle_cycles;
  logic             en;
  logic [N_REQ-1:0] ack;
  logic [1:0]       state;

  int errors = 0;
  int checks = 0;

  m_or_cg_ctrl #(.N_REQ(N_REQ), .CNT_W(CNT_W), .WAKE_CYC(WAKE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .force_on(force_on),
    .idle_cycles(idle_cycles), .en(en), .ack(ack), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: en rises on the first edge seeing a request, ON is reached at a
  // fixed edge number, and OFF is a deadline set when requests vanish.
  int m_edge, on_at, drop_at;
  bit m_en, m_hold;

  function automatic logic [1:0] m_state();
    if (!m_en)            return 2'd0;
    if (m_edge < on_at)   return 2'd1;
    if (m_hold)           return 2'd3;
    return 2'd2;
  endfunction

  initial begin
    m_en = 0; m_hold = 0; m_edge = 0; on_at = 0; drop_at = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_en = 0; m_hold = 0; m_edge = 0; on_at = 0; drop_at = 0;
      end else begin
        bit any_s;
        any_s = (|(req & ~mask)) | force_on;
        m_edge++;
        if (!m_en) begin
          if (any_s) begin
            m_en = 1; m_hold = 0; on_at = m_edge + WAKE_CYC;
          end
        end else if (m_edge <= on_at) begin
          // still waking; requests are irrelevant until on_at
        end else if (!m_hold) begin
          if (!any_s) begin
            m_hold = 1; drop_at = m_edge + int'(idle_cycles) + 1;
          end
        end else if (any_s) begin
          m_hold = 0;
        end else if (m_edge == drop_at) begin
          m_en = 0; m_hold = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_en", 32'(en), 32'(m_en));
      chk("model_state", 32'(state), 32'(m_state()));
      chk("model_ack", 32'(ack), (m_state() == 2'd2) ? 32'(req & ~mask) : 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'hF; mask = '0; force_on = 1'b0; idle_cycles = 4'd3;
    #3;
    chk("reset_en", 32'(en), 0);
    chk("reset_ack", 32'(ack), 0);
    chk("reset_state", 32'(state), 0);
    step(1);
    req = '0;
    rst_n = 1'b1;
    step(10);
    chk("idle_en", 32'(en), 0);
    chk("idle_state", 32'(state), 0);

    // wake latency
    req = 4'b0010;
    step(1);
    chk("wake0_en", 32'(en), 1);
    chk("wake0_state", 32'(state), 1);
    chk("wake0_ack", 32'(ack), 0);
    chk("model_wake0", 32'(m_state()), 1);
    step(1);
    chk("wake1_state", 32'(state), 1);
    chk("wake1_ack", 32'(ack), 0);
    step(1);
    chk("on_state", 32'(state), 2);
    chk("on_ack", 32'(ack), 4'b0010);
    chk("model_on", 32'(m_state()), 2);

    // hysteresis idle=3
    step(3);
    idle_cycles = 4'd3;
    req = '0;
    step(1);
    chk("hold_state", 32'(state), 3);
    chk("hold_ack", 32'(ack), 0);
    idle_cycles = 4'd0;
    step(3);
    chk("hold3_en", 32'(en), 1);
    chk("hold3_state", 32'(state), 3);
    step(1);
    chk("drop_en", 32'(en), 0);
    chk("drop_state", 32'(state), 0);
    chk("model_drop", 32'(m_en), 0);

    // hysteresis idle=0
    req = 4'b0001;
    step(3);
    chk("on2_state", 32'(state), 2);
    req = '0;
    step(1);
    chk("hold0_state", 32'(state), 3);
    chk("hold0_en", 32'(en), 1);
    step(1);
    chk("drop0_en", 32'(en), 0);

    // re-request exactly at expiry
    idle_cycles = 4'd2;
    req = 4'b0100;
    step(3);
    req = '0;
    step(3);
    chk("race_pre_state", 32'(state), 3);
    req = 4'b0100;
    step(1);
    chk("race_state", 32'(state), 2);
    chk("race_en", 32'(en), 1);
    chk("race_ack", 32'(ack), 4'b0100);

    // re-request one cycle late
    req = '0;
    step(4);
    chk("late_off_state", 32'(state), 0);
    chk("late_off_en", 32'(en), 0);
    req = 4'b0100;
    step(2);
    chk("late_wake_state", 32'(state), 1);
    chk("late_wake_ack", 32'(ack), 0);
    step(1);
    chk("late_on_ack", 32'(ack), 4'b0100);

    // mask / force
    req = 4'b1001; mask = 4'b1000;
    #1;
    chk("mask_ack", 32'(ack), 4'b0001);
    step(1);
    mask = 4'b1001;
    #1;
    chk("mask_all_ack", 32'(ack), 0);
    step(1);
    chk("mask_hold", 32'(state), 3);
    mask = 4'hF; force_on = 1'b1;
    step(3);
    chk("force_en", 32'(en), 1);
    chk("force_state", 32'(state), 2);
    chk("force_ack", 32'(ack), 0);
    force_on = 1'b0; mask = '0; req = 4'b0011;
    step(1);

    // async reset mid-ON
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(en), 0);
    chk("arst_ack", 32'(ack), 0);
    chk("arst_state", 32'(state), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rewake0", 32'(state), 1);
    step(1);
    chk("rewake1", 32'(state), 1);
    chk("rewake1_ack", 32'(ack), 0);
    step(1);
    chk("rewake_on", 32'(state), 2);
    chk("rewake_ack", 32'(ack), 4'b0011);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 3) == 0)
        req = ($urandom_range(0, 1) == 0) ? '0 : N_REQ'($urandom);
      if ($urandom_range(0, 7) == 0) mask = N_REQ'($urandom) & N_REQ'($urandom);
      force_on = ($urandom_range(0, 29) == 0);
      idle_cycles = CNT_W'($urandom_range(0, 5));
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_or_cg_ctrl.md
# m_or_cg_ctrl

Parametrised clock-enable request combiner with wake-up latency and idle hysteresis. It is the sequential successor to the 2-input clock OR cell. It ORs N masked enable requests and drives one registered, glitch-free gate enable for a downstream clock-gate cell. It holds that enable for a programmable number of idle cycles before dropping it, and it acknowledges each requester only once the gated clock has had time to come up. It sits between block-level clock requesters and the technology clock-gate cell in the clock-control path.

## Interface
- N_REQ, 4, number of request channels (1..32)
- CNT_W, 4, width of the shared down-counter and of idle_cycles
- WAKE_CYC, 2, cycles en must be high before ack is given (1..2^CNT_W)
- clk  input  1  block clock (ungated source clock)
- rst_n  input  1  reset; asynchronous, active-low
- req  input  N_REQ  per-channel enable request, level
- mask  input  N_REQ  1 = channel ignored
- force_on  input  1  treated as an extra unmaskable request
- idle_cycles  input  CNT_W  hysteresis length; sampled on entry to HOLD
- en  output  1  gate enable, driven directly from a flop
- ack  output  N_REQ  channel i served: req[i] & ~mask[i] & (state==ON)
- state  output  2  OFF=0, WAKE=1, ON=2, HOLD=3

## Operation
- any = |(req & ~mask) | force_on, combinational.
- Flops: state, en, cnt[CNT_W-1:0]. en is a dedicated flop; it is never decoded combinationally from state.
- OFF: en=0. If any, go to WAKE, set en=1, and load cnt=WAKE_CYC-1.
- WAKE: if cnt==0, go to ON; otherwise decrement cnt. any is ignored here. A request that drops mid-WAKE does not abort WAKE, which guarantees a minimum on-time.
- ON: if !any, go to HOLD and load cnt=idle_cycles; otherwise stay.
- HOLD: if any, go to ON; this takes priority over expiry. Else, if cnt==0, go to OFF and set en=0. Else decrement cnt.
- en=1 in WAKE, ON and HOLD; en=0 in OFF.
- ack is 0 outside ON. In ON it follows req and mask combinationally, per channel.
- Masking a channel while in ON removes its ack in the same cycle. If that leaves any=0, the block enters HOLD at the next edge.
- Counter is unsigned and never wraps; decrement only when cnt!=0.

## Timing
- Reset (rst_n low, asynchronous): state=OFF, en=0, cnt=0, ack=0 immediately. Outputs hold these values until the first edge after rst_n deasserts.
- Reset mid-WAKE, ON or HOLD: en falls asynchronously. No HOLD time is honoured.
- Wake latency:
  - any sampled high at edge 0 gives en=1 after edge 0.
  - state=ON after edge WAKE_CYC.
  - ack is visible from edge WAKE_CYC.
- Release latency:
  - any low at edge k gives HOLD after edge k.
  - en=0 after edge k+idle_cycles+1.
  - idle_cycles=0 therefore gives exactly one HOLD cycle.
- Re-request in HOLD at edge j gives ON after edge j, with ack from then on and no WAKE repeated.
- Re-request in the same cycle as HOLD expiry (cnt==0, any=1) goes to ON; en never drops.
- Re-request arriving one cycle after en falls goes through a full WAKE.
- Changing idle_cycles during HOLD has no effect until the next HOLD entry.
- en has no combinational path from any input; it makes at most one transition per clock.

## Test plan
- Reset/idle: rst_n=0 with req=4'hF → en=0, ack=0, state=0. Release rst_n with req=0 for 10 cycles → en stays 0.
- Wake: WAKE_CYC=2, req=4'b0010 at edge 0 → en=1 after edge 0, state=ON after edge 2, ack=4'b0010 from edge 2. A bench check confirms ack=0 during both WAKE cycles.
- Hysteresis: in ON with idle_cycles=3, drop req at edge 10 → HOLD after edge 10, en=0 after edge 14. Repeat with idle_cycles=0 → en=0 after edge 11.
- HOLD re-request and expiry race: idle_cycles=2, req returns exactly when cnt==0 → state ON and en held high throughout. Req one cycle later → OFF, then WAKE for 2 cycles before ack.
- Mask/force: req=4'b1001, mask=4'b1000 in ON → ack=4'b0001. Mask=4'b1001 → ack=0 and HOLD next edge. force_on=1 with all masked → en=1 and ack=0.
- Async reset mid-ON: rst_n low between edges → en=0 and ack=0 before the next edge. After release with req held → fresh WAKE of WAKE_CYC cycles.
